sram_arbiter: RTL

Parametrised N-port memory arbiter between the requesters in `toplevel` (vector unit memory port, scalar core, future DMA) and a single-port, fixed-latency `sram`. It replaces the point-to-point vproc↔mmu↔sram wiring. It adds three things the direct path lacks: a per-port grant handshake, round-robin or fixed-priority arbitration, and address-range checking with error responses. Responses come back to the issuing port, in order, on the vproc-style `rvalid`/`err`/`rdata` channel.

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_arbiter_rr.sv | 33 +++
 rtl/sram_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types and helpers for the N-port SRAM arbiter
//   arb_mode_e : ARB_RR (round-robin) / ARB_FIXED (lowest index wins)
//   rsp_tag_t  : response tag {valid, port, err}; port field sized for up to 2**TAG_PORT_W ports
//   idx_w()    : index width for n items, minimum 1
package sram_arbiter_pkg;
   typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
   localparam int TAG_PORT_W = 8;
   typedef struct packed {
      logic                  valid;
      logic [TAG_PORT_W-1:0] port;
      logic                  err;
   } rsp_tag_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sram_arbiter_rr.sv
// rr_arbiter: combinational N-way pick, round-robin from a pointer or fixed lowest-index
//   req_i  : request vector
//   ptr_i  : round-robin start index (ignored in ARB_FIXED)
//   mode_i : arbitration mode
//   gnt_o  : one-hot grant (all zero when nothing requests)
//   idx_o  : index of the granted port
module rr_arbiter import sram_arbiter_pkg::*; #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  arb_mode_e     mode_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   int   w_p;
   logic w_found;
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      w_found = 1'b0;
      w_p     = 0;
      for (int k = 0; k < N; k++) begin
         w_p = (mode_i == ARB_FIXED) ? k : (int'(ptr_i) + k) % N;
         if (!w_found && req_i[w_p]) begin
            w_found    = 1'b1;
            gnt_o[w_p] = 1'b1;
            idx_o      = IW'(w_p);
         end
      end
   end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: N-port arbiter in front of a single-port fixed-latency SRAM
//   clk, rst (async, active-low)
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i : per-port request, accepted on req_i & gnt_o
//   rvalid_o/err_o/rdata_o               : per-port in-order response, SRAM_LAT cycles after accept
//   sram_*                               : SRAM command (combinational) and read data
module sram_arbiter import sram_arbiter_pkg::*; #(
   parameter int                NUM_PORTS  = 2,
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                SRAM_DEPTH = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                SRAM_LAT   = 1,
   parameter arb_mode_e         ARB_MODE   = ARB_RR
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_PORTS-1:0]                  req_i,
   output logic [NUM_PORTS-1:0]                  gnt_o,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      addr_i,
   input  logic [NUM_PORTS-1:0]                  we_i,
   input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]    be_i,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]      wdata_i,
   output logic [NUM_PORTS-1:0]                  rvalid_o,
   output logic [NUM_PORTS-1:0]                  err_o,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]      rdata_o,
   output logic                                  sram_req_o,
   output logic                                  sram_we_o,
   output logic [$clog2(SRAM_DEPTH)-1:0]         sram_addr_o,
   output logic [DATA_W/8-1:0]                   sram_be_o,
   output logic [DATA_W-1:0]                     sram_wdata_o,
   input  logic [DATA_W-1:0]                     sram_rdata_i
);
   localparam int              PW   = idx_w(NUM_PORTS);
   localparam int              BW   = DATA_W / 8;
   localparam int              AW   = $clog2(SRAM_DEPTH);
   localparam int              OFF  = $clog2(BW);
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(SRAM_DEPTH * BW);

   logic [PW-1:0]             r_rr;
   rsp_tag_t [SRAM_LAT-1:0]   r_tag;
   logic [NUM_PORTS-1:0]      w_gnt;
   logic [PW-1:0]             w_idx;
   logic                      w_acc;
   logic                      w_in;
   logic                      w_sram;
   logic [ADDR_W-1:0]         w_addr;
   logic [ADDR_W-1:0]         w_off;
   rsp_tag_t                  w_new;
   rsp_tag_t                  w_tail;

   // requests are masked while reset is asserted so nothing is granted or issued
   rr_arbiter #(.N(NUM_PORTS), .IW(PW)) u_arb (
      .req_i  (req_i & {NUM_PORTS{rst}}),
      .ptr_i  (r_rr),
      .mode_i (ARB_MODE),
      .gnt_o  (w_gnt),
      .idx_o  (w_idx)
   );

   assign gnt_o  = w_gnt;
   assign w_acc  = |w_gnt;
   assign w_addr = addr_i[w_idx];
   assign w_off  = w_addr - BASE_ADDR;
   // one extra bit so a window ending exactly at the top of the address space still compares correctly
   assign w_in   = ({1'b0, w_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_addr} < {1'b0, BASE_ADDR} + SPAN);
   assign w_sram = w_acc & w_in;

   assign sram_req_o   = w_sram;
   assign sram_we_o    = w_sram & we_i[w_idx];
   assign sram_addr_o  = w_sram ? AW'(w_off >> OFF) : '0;
   assign sram_be_o    = w_sram ? be_i[w_idx] : '0;
   assign sram_wdata_o = w_sram ? wdata_i[w_idx] : '0;

   assign w_new = '{valid: w_acc, port: TAG_PORT_W'(w_idx), err: w_acc & ~w_in};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr  <= '0;
         r_tag <= '0;
      end else begin
         if (w_acc) r_rr <= (w_idx == PW'(NUM_PORTS - 1)) ? '0 : w_idx + 1'b1;
         r_tag[0] <= w_new;
         for (int i = 1; i < SRAM_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign w_tail = r_tag[SRAM_LAT-1];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rsp
      assign rvalid_o[g] = w_tail.valid && (w_tail.port == TAG_PORT_W'(g));
      assign err_o[g]    = rvalid_o[g] && w_tail.err;
      assign rdata_o[g]  = (w_tail.valid && !w_tail.err) ? sram_rdata_i : '0;
   end
endmodule
